// File: rtl/synapse_scheduler_if.sv
// Event handshake from the synapse scheduler to the shared dendrite update unit.
// The master side presents one synapse index at a time; the slave side accepts it.
interface synapse_scheduler_if #(
  parameter int S = 16
) ();
  localparam int SW = $clog2(S);

  logic          ev_valid;
  logic [SW-1:0] ev_syn;
  logic          ev_ready;

  modport master (output ev_valid, output ev_syn, input ev_ready);
  modport slave  (input ev_valid, input ev_syn, output ev_ready);
endinterface

// File: rtl/synapse_scheduler.sv
// Time-step sequencer: keeps a T-deep spike history and a writable S-entry
// connection table, and serialises one event per active synapse on every tick.
module synapse_scheduler #(
  parameter int T = 4,
  parameter int N = 8,
  parameter int S = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [N-1:0]         spike_now,
  input  logic                 cfg_we,
  input  logic [$clog2(S)-1:0] cfg_addr,
  input  logic [$clog2(N)-1:0] cfg_src,
  input  logic [$clog2(T)-1:0] cfg_delay,
  output logic                 cfg_ready,
  output logic                 busy,
  output logic                 step_done,
  output logic                 overrun,
  synapse_scheduler_if.master  ev
);
  localparam int TW = $clog2(T);
  localparam int NW = $clog2(N);
  localparam int SW = $clog2(S);
  localparam logic [SW-1:0] LAST_IDX = SW'(S - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] j_q, j_d;
  logic [N-1:0]  hist_q [T];
  logic [NW-1:0] src_q  [S];
  logic [TW-1:0] dly_q  [S];
  logic          overrun_q;

  logic          cur_active_s;
  logic          tick_accept_s;
  logic          cfg_write_s;
  logic          ev_valid_s;

  // Out-of-range source or tap is stored as written but never reads as active.
  always_comb begin
    cur_active_s = 1'b0;
    if ((int'(dly_q[j_q]) < T) && (int'(src_q[j_q]) < N)) begin
      cur_active_s = hist_q[dly_q[j_q]][src_q[j_q]];
    end else begin
      cur_active_s = 1'b0;
    end
  end

  // Next-state logic; a presented event holds the index until ev_ready.
  always_comb begin
    state_d       = state_q;
    j_d           = j_q;
    tick_accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          tick_accept_s = 1'b1;
          j_d           = SW'(0);
          state_d       = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (cur_active_s && !ev.ev_ready) begin
          state_d = ST_SCAN;
        end else if (j_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          j_d = j_q + SW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        j_d     = SW'(0);
      end
    endcase
  end

  // Outputs are decoded from registered state only, never from ev_ready.
  assign ev_valid_s  = (state_q == ST_SCAN) && cur_active_s;
  assign ev.ev_valid = ev_valid_s;
  assign ev.ev_syn   = ev_valid_s ? j_q : SW'(0);
  assign busy        = (state_q != ST_IDLE);
  assign cfg_ready   = (state_q == ST_IDLE);
  assign step_done   = (state_q == ST_DONE);
  assign overrun     = overrun_q;
  assign cfg_write_s = cfg_we && (state_q == ST_IDLE);

  // State, history, table and sticky overrun; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      j_q       <= SW'(0);
      overrun_q <= 1'b0;
      for (int k = 0; k < T; k++) begin
        hist_q[k] <= N'(0);
      end
      for (int s = 0; s < S; s++) begin
        src_q[s] <= NW'(0);
        dly_q[s] <= TW'(0);
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      if (tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (tick_accept_s) begin
        for (int k = T - 1; k > 0; k--) begin
          hist_q[k] <= hist_q[k-1];
        end
        hist_q[0] <= spike_now;
      end
      if (cfg_write_s) begin
        src_q[cfg_addr] <= cfg_src;
        dly_q[cfg_addr] <= cfg_delay;
      end
    end
  end
endmodule

// File: tb/tb_synapse_scheduler.sv
// Self-checking bench for synapse_scheduler: directed scenarios plus randomized
// steps, compared against a list-of-events reference model of the step rules.
module tb_synapse_scheduler;
  localparam int T  = 4;
  localparam int N  = 8;
  localparam int S  = 16;
  localparam int TW = $clog2(T);
  localparam int NW = $clog2(N);
  localparam int SW = $clog2(S);

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [N-1:0]  spike_now;
  logic          cfg_we;
  logic [SW-1:0] cfg_addr;
  logic [NW-1:0] cfg_src;
  logic [TW-1:0] cfg_delay;
  logic          cfg_ready, busy, step_done, overrun;

  synapse_scheduler_if #(.S(S)) ev ();

  synapse_scheduler #(.T(T), .N(N), .S(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .spike_now (spike_now),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_src   (cfg_src),
    .cfg_delay (cfg_delay),
    .cfg_ready (cfg_ready),
    .busy      (busy),
    .step_done (step_done),
    .overrun   (overrun),
    .ev        (ev)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: history list, table, sticky flag
  logic [N-1:0] m_hist [T];
  int           m_src  [S];
  int           m_dly  [S];
  bit           m_ovr;
  int           exp_q[$];

  task automatic model_reset();
    for (int k = 0; k < T; k++) m_hist[k] = '0;
    for (int j = 0; j < S; j++) begin
      m_src[j] = 0;
      m_dly[j] = 0;
    end
    m_ovr = 1'b0;
  endtask

  task automatic model_tick(input logic [N-1:0] v);
    for (int k = T - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = v;
    exp_q.delete();
    for (int j = 0; j < S; j++) begin
      if (m_dly[j] < T && m_src[j] < N) begin
        if (m_hist[m_dly[j]][m_src[j]]) exp_q.push_back(j);
      end
    end
  endtask

  task automatic cfg_write(input int a, input int s, input int d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = SW'(a);
    cfg_src   = NW'(s);
    cfg_delay = TW'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    m_src[a] = s;
    m_dly[a] = d;
  endtask

  // stall < 0 picks a random 0..2 stall per event; inject fires tick+cfg mid-scan
  task automatic run_step(input logic [N-1:0] v, input int stall, input bit inject, input string name);
    int  got[$];
    int  cyc, total, stall_left, held;
    bit  holding, seen_done, bad;
    @(negedge clk);
    tick = 1'b1;
    spike_now = v;
    ev.ev_ready = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    model_tick(v);
    cyc = 1; total = 0; holding = 1'b0; seen_done = 1'b0; held = 0; stall_left = 0;
    while (!seen_done && cyc < 8 * S + 50) begin
      if (inject && cyc == 3) begin
        tick = 1'b1; spike_now = 8'h80;
        cfg_we = 1'b1; cfg_addr = SW'(2); cfg_src = NW'(7); cfg_delay = TW'(0);
        m_ovr = 1'b1;
      end else begin
        tick = 1'b0;
        cfg_we = 1'b0;
      end
      if (step_done) begin
        seen_done = 1'b1;
        checks++;
        if (cyc != S + 1 + total || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s step_len: step_done at cycle %0d busy=%b, expected cycle %0d busy=1", name, cyc, busy, S + 1 + total);
        end
      end else begin
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s scan_busy: cycle %0d busy=%b cfg_ready=%b, expected 1/0", name, cyc, busy, cfg_ready);
        end
        if (ev.ev_valid === 1'b1) begin
          if (holding) begin
            checks++;
            if (ev.ev_syn !== SW'(held)) begin
              failures++;
              $display("FAIL %s stall_hold: ev_syn=%0d, expected held %0d", name, ev.ev_syn, held);
            end
          end else begin
            held = int'(ev.ev_syn);
            stall_left = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            holding = 1'b1;
          end
          if (stall_left > 0) begin
            ev.ev_ready = 1'b0;
            stall_left--;
            total++;
          end else begin
            ev.ev_ready = 1'b1;
            got.push_back(int'(ev.ev_syn));
            holding = 1'b0;
          end
        end else begin
          if (holding) begin
            checks++;
            failures++;
            $display("FAIL %s stall_drop: ev_valid=%b during stall, expected 1", name, ev.ev_valid);
            holding = 1'b0;
          end
          ev.ev_ready = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    tick = 1'b0;
    cfg_we = 1'b0;
    ev.ev_ready = 1'b1;
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: no step_done after %0d cycles, expected at %0d", name, cyc, S + 1 + total);
    end
    checks++;
    bad = (got.size() != exp_q.size());
    for (int i = 0; i < got.size() && !bad; i++) if (got[i] != exp_q[i]) bad = 1'b1;
    if (bad) begin
      failures++;
      $display("FAIL %s events: got %p, expected %p", name, got, exp_q);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || step_done !== 1'b0 || overrun !== m_ovr) begin
      failures++;
      $display("FAIL %s after_step: busy=%b cfg_ready=%b step_done=%b overrun=%b, expected 0/1/0/%b",
               name, busy, cfg_ready, step_done, overrun, m_ovr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; spike_now = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_src = '0; cfg_delay = '0; ev.ev_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ev.ev_valid !== 1'b0 || ev.ev_syn !== SW'(0) || busy !== 1'b0 || step_done !== 1'b0 ||
        overrun !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b syn=%0d busy=%b done=%b ovr=%b cfg_ready=%b, expected 0/0/0/0/0/1",
               ev.ev_valid, ev.ev_syn, busy, step_done, overrun, cfg_ready);
    end
    reset = 1'b0;
    model_reset();
    run_step(8'h00, 0, 1'b0, "reset_empty_step");
  endtask

  task automatic test_single_spike();
    cfg_write(5, 3, 2);
    run_step(8'h08, 0, 1'b0, "single_step1");
    run_step(8'h00, 0, 1'b0, "single_step2");
    run_step(8'h00, 0, 1'b0, "single_step3");
  endtask

  task automatic test_fanout();
    for (int j = 0; j < S; j++) cfg_write(j, (j == 2 || j == 9 || j == 15) ? 0 : 7, 0);
    run_step(8'h01, 0, 1'b0, "fanout");
  endtask

  task automatic test_backpressure();
    run_step(8'h01, 3, 1'b0, "backpressure");
  endtask

  task automatic test_overrun_lockout();
    run_step(8'h01, 0, 1'b1, "overrun_step");
    cfg_write(4, 0, 1);
    cfg_write(5, 7, 1);
    run_step(8'h01, 0, 1'b0, "overrun_rerun");
  endtask

  task automatic test_reset_mid_scan();
    int  cyc;
    bit  found;
    @(negedge clk);
    tick = 1'b1; spike_now = 8'h01; ev.ev_ready = 1'b0;
    @(negedge clk);
    tick = 1'b0;
    cyc = 0; found = 1'b0;
    while (!found && cyc < S + 5) begin
      if (ev.ev_valid === 1'b1) found = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midscan_wait: ev_valid=%b after %0d cycles, expected 1", ev.ev_valid, cyc);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ev.ev_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL midscan_reset: valid=%b busy=%b ovr=%b cfg_ready=%b, expected 0/0/0/1",
               ev.ev_valid, busy, overrun, cfg_ready);
    end
    reset = 1'b0;
    ev.ev_ready = 1'b1;
    model_reset();
    run_step(8'h01, 0, 1'b0, "midscan_all16");
  endtask

  task automatic test_random();
    logic [N-1:0] spk;
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 5)); w++) begin
        cfg_write(int'($urandom_range(0, S - 1)), int'($urandom_range(0, N - 1)), int'($urandom_range(0, T - 1)));
      end
      spk = N'($urandom_range(0, (1 << N) - 1));
      run_step(spk, -1, 1'b0, "random_step");
    end
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_fanout();
    test_backpressure();
    test_overrun_lockout();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
